// File: rtl/mig_seq_evaluator.sv
// mig_seq_evaluator: time-multiplexed evaluator for a programmable majority-inverter graph.
// A single 3-input majority unit computes one node per cycle from the program RAM.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_we/addr/data      program slot write {inv_a,sel_a,inv_b,sel_b,inv_c,sel_c}
//   cfg_nodes             node count, sampled on cfg_we, saturates at MAX_NODES
//   cfg_err               one-cycle pulse when a write arrives while busy
//   in_valid/in_ready/in_x   input vector handshake (ready only in IDLE)
//   out_valid/out_ready/out_y result handshake, out_y = last node value
//   busy                  evaluation or result pending
module mig_seq_evaluator #(
   parameter int NUM_IN    = 7,
   parameter int MAX_NODES = 8,
   parameter int SEL_W     = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               cfg_we,
   input  logic [$clog2(MAX_NODES)-1:0]       cfg_addr,
   input  logic [3*(SEL_W+1)-1:0]             cfg_data,
   input  logic [$clog2(MAX_NODES+1)-1:0]     cfg_nodes,
   output logic                               cfg_err,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [NUM_IN-1:0]                  in_x,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic                               out_y,
   output logic                               busy
);
   localparam int KW    = $clog2(MAX_NODES);
   localparam int NW    = $clog2(MAX_NODES+1);
   localparam int OW    = SEL_W + 1;
   localparam int SRC_W = 2**SEL_W;
   typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;
   state_t state, state_nx;
   logic [3*OW-1:0]    prog [MAX_NODES];
   logic [NUM_IN-1:0]  x_r;
   logic [MAX_NODES-1:0] node_q;
   logic [NW-1:0]      nodes;
   logic [KW-1:0]      k;
   logic [KW-1:0]      last_idx;
   logic [3*OW-1:0]    instr;
   logic [SRC_W-1:0]   src;
   logic               a, b, c, nv, accept, last_k;
   // Operand = optional inversion of one entry of the flat source vector {nodes, x, const0};
   // unused select codes above the node range read as zero through the padding.
   function automatic logic opnd(input logic [OW-1:0] f, input logic [SRC_W-1:0] s);
      return f[OW-1] ^ s[f[SEL_W-1:0]];
   endfunction
   always_comb begin
      instr     = prog[k];
      src       = SRC_W'({node_q, x_r, 1'b0});
      a         = opnd(instr[3*OW-1 -: OW], src);
      b         = opnd(instr[2*OW-1 -: OW], src);
      c         = opnd(instr[OW-1:0], src);
      nv        = (a & b) | (a & c) | (b & c);
      last_idx  = KW'(nodes - NW'(1));
      last_k    = NW'(k) == nodes - NW'(1);
      in_ready  = state == IDLE;
      busy      = state != IDLE;
      out_valid = state == DONE;
      accept    = in_valid & in_ready;
      out_y     = (out_valid && nodes != '0) ? node_q[last_idx] : 1'b0;
      state_nx  = state == IDLE ? (accept ? (nodes == '0 ? DONE : EVAL) : IDLE) :
                  state == EVAL ? (last_k ? DONE : EVAL) :
                  (out_ready ? IDLE : DONE);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < MAX_NODES; i++) prog[i] <= '0;
         x_r     <= '0;
         node_q  <= '0;
         nodes   <= '0;
         k       <= '0;
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= cfg_we & busy;
         if (cfg_we && !busy) begin
            prog[cfg_addr] <= cfg_data;
            nodes <= cfg_nodes > NW'(MAX_NODES) ? NW'(MAX_NODES) : cfg_nodes;
         end
         // Clearing the node file at accept makes forward/self references read 0.
         if (accept) begin
            x_r    <= in_x;
            node_q <= '0;
            k      <= '0;
         end else if (state == EVAL) begin
            node_q[k] <= nv;
            k         <= k + 1'b1;
         end
      end
endmodule

// File: tb/tb_mig_seq_evaluator.sv
// tb_mig_seq_evaluator: directed scoreboard bench for mig_seq_evaluator.
module tb_mig_seq_evaluator;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_we = 1'b0;
   logic [2:0]  cfg_addr = '0;
   logic [14:0] cfg_data = '0;
   logic [3:0]  cfg_nodes = '0;
   logic        cfg_err;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [6:0]  in_x = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_y;
   logic        busy;
   int          n_tests = 0;
   int          n_fail = 0;
   logic [14:0] prog_m [8];
   int          nodes_m = 0;
   logic        q [$];
   mig_seq_evaluator dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .cfg_nodes(cfg_nodes), .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   function automatic logic [4:0] xs(input int i);
      return 5'(i + 1);
   endfunction
   function automatic logic [4:0] ns(input int j);
      return 5'(8 + j);
   endfunction
   function automatic logic model(input logic [6:0] x);
      logic [7:0] nd;
      logic [2:0] v;
      logic [4:0] f;
      int s;
      nd = '0;
      for (int j = 0; j < nodes_m; j++) begin
         for (int o = 0; o < 3; o++) begin
            f = prog_m[j][14-5*o -: 5];
            s = int'(f[3:0]);
            v[o] = (s == 0) ? 1'b0 : (s <= 7) ? x[s-1] : nd[s-8];
            v[o] = v[o] ^ f[4];
         end
         nd[j] = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
      end
      return nodes_m == 0 ? 1'b0 : nd[nodes_m-1];
   endfunction
   task automatic write_cfg(input logic [2:0] a, input logic [14:0] d, input logic [3:0] n);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d; cfg_nodes = n;
      prog_m[a] = d;
      nodes_m = n > 8 ? 8 : int'(n);
      @(negedge clk);
      cfg_we = 1'b0;
      check("cfg_err_idle", cfg_err, 0);
   endtask
   task automatic run_vec(input logic [6:0] x, input logic ey, input int el);
      int lat;
      @(negedge clk);
      check("in_ready_idle", in_ready, 1);
      in_valid = 1'b1; in_x = x;
      q.push_back(ey);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", lat, el);
      check("out_y", out_y, q.size() > 0 ? q.pop_front() : 1'bx);
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
   endtask
   initial begin
      logic [6:0] vec [4];
      logic ey;
      int cyc, acc, got, last_acc, lat;
      for (int i = 0; i < 8; i++) prog_m[i] = '0;
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_y", out_y, 0);
      check("rst_cfg_err", cfg_err, 0);
      check("rst_busy", busy, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      // Seven-node reference net
      write_cfg(3'd0, {xs(0), xs(4), xs(5)}, 4'd7);
      write_cfg(3'd1, {xs(1), xs(3), xs(5)}, 4'd7);
      write_cfg(3'd2, {xs(0), xs(2), ns(1)}, 4'd7);
      write_cfg(3'd3, {xs(0), xs(1), xs(4)}, 4'd7);
      write_cfg(3'd4, {xs(0), xs(3), ns(3)}, 4'd7);
      write_cfg(3'd5, {xs(1), xs(6), ns(0)}, 4'd7);
      write_cfg(3'd6, {ns(2), ns(4), ns(5)}, 4'd7);
      run_vec(7'b0010011, 1'b1, 8);
      run_vec(7'h00, 1'b0, 8);
      run_vec(7'h7F, 1'b1, 8);
      for (int v = 0; v < 128; v++) run_vec(7'(v), model(7'(v)), 8);
      // Backpressure with a rejected config write in the stall window
      @(negedge clk);
      in_valid = 1'b1; in_x = 7'h35;
      ey = model(7'h35);
      q.push_back(ey);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("bp_latency", lat, 8);
      check("bp_y", out_y, q.size() > 0 ? q.pop_front() : 1'bx);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin cfg_we = 1'b1; cfg_addr = 3'd6; cfg_data = '0; cfg_nodes = 4'd1; end
         @(posedge clk); #1;
         cfg_we = 1'b0;
         check("bp_out_valid", out_valid, 1);
         check("bp_out_y_stable", out_y, ey);
         check("bp_in_ready", in_ready, 0);
         check("bp_cfg_err", cfg_err, i == 3);
      end
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      run_vec(7'h35, model(7'h35), 8);
      run_vec(7'h4A, model(7'h4A), 8);
      // Back-to-back with in_valid held and out_ready high
      vec[0] = 7'h13; vec[1] = 7'h6C; vec[2] = 7'h7F; vec[3] = 7'h21;
      cyc = 0; acc = 0; got = 0; last_acc = 0;
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; in_x = vec[0];
      while (got < 4 && cyc < 200) begin
         if (in_valid && in_ready) begin
            q.push_back(model(in_x));
            if (acc > 0) check("b2b_gap", cyc - last_acc, 9);
            last_acc = cyc;
            acc++;
         end
         if (out_valid) begin
            check("b2b_y", out_y, q.size() > 0 ? q.pop_front() : 1'bx);
            got++;
         end
         @(posedge clk); #1;
         cyc++;
         if (acc == 4) in_valid = 1'b0;
         else in_x = vec[acc];
         @(negedge clk);
      end
      check("b2b_count", got, 4);
      in_valid = 1'b0; out_ready = 1'b0;
      // Saturation of node count; slot 7 references itself (reads 0) inverted
      write_cfg(3'd7, {5'b10000 | ns(7), ns(6), 5'd0}, 4'd15);
      run_vec(7'b0010011, model(7'b0010011), 9);
      run_vec(7'h2A, model(7'h2A), 9);
      // Single inverted-constant node and empty program
      write_cfg(3'd0, {5'b10000, xs(0), 5'd0}, 4'd1);
      run_vec(7'h01, 1'b1, 2);
      run_vec(7'h7E, 1'b0, 2);
      write_cfg(3'd5, '0, 4'd0);
      run_vec(7'h7F, 1'b0, 1);
      // Asynchronous reset in the middle of an evaluation
      write_cfg(3'd0, {xs(0), xs(4), xs(5)}, 4'd8);
      @(negedge clk);
      in_valid = 1'b1; in_x = 7'h7F;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_out_valid", out_valid, 0);
      check("arst_in_ready", in_ready, 1);
      q.delete();
      for (int i = 0; i < 8; i++) prog_m[i] = '0;
      nodes_m = 0;
      @(negedge clk);
      rst_n = 1'b1;
      write_cfg(3'd7, {ns(0), ns(6), 5'b10000}, 4'd8);
      run_vec(7'h7F, 1'b0, 9);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
